// File: rtl/serializador_paralelo_serial.sv
// Parallel-in, serial-out transmitter for the serial link.
// A word is captured on an accepted load, then driven onto serial_out one bit
// per clock with busy high. A single-cycle done pulse follows the last bit.
// All outputs are registered so the serial line is glitch-free.

module serializador_paralelo_serial #(
  parameter int unsigned WIDTH     = 4,
  parameter bit          LSB_FIRST = 1'b1,
  parameter int unsigned CNT_W     = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  output logic             serial_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] bit_index
);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  localparam logic [CNT_W-1:0] LastIdx = CNT_W'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [CNT_W-1:0] cnt_q;

  logic             first_bit;
  logic             next_bit;
  logic [WIDTH-1:0] shreg_shifted;

  // Select the output end of the shift register according to bit order.
  always_comb begin
    first_bit     = 1'b0;
    next_bit      = 1'b0;
    shreg_shifted = '0;
    if (LSB_FIRST) begin
      first_bit     = data_in[0];
      next_bit      = shreg_q[1];
      shreg_shifted = shreg_q >> 1;
    end else begin
      first_bit     = data_in[WIDTH-1];
      next_bit      = shreg_q[WIDTH-2];
      shreg_shifted = shreg_q << 1;
    end
  end

  // Control FSM with registered outputs; load is only honoured in IDLE/DONE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      shreg_q    <= '0;
      cnt_q      <= '0;
      serial_out <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      bit_index  <= '0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (load) begin
            state_q    <= StShift;
            shreg_q    <= data_in;
            cnt_q      <= '0;
            serial_out <= first_bit;
            busy       <= 1'b1;
            done       <= 1'b0;
            bit_index  <= '0;
          end else begin
            state_q    <= StIdle;
            serial_out <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            bit_index  <= '0;
          end
        end
        StShift: begin
          if (cnt_q == LastIdx) begin
            // Last bit has been held for its cycle; line returns low.
            state_q    <= StDone;
            shreg_q    <= '0;
            cnt_q      <= '0;
            serial_out <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
            bit_index  <= '0;
          end else begin
            shreg_q    <= shreg_shifted;
            cnt_q      <= cnt_q + CNT_W'(1);
            serial_out <= next_bit;
            bit_index  <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q    <= StIdle;
          shreg_q    <= '0;
          cnt_q      <= '0;
          serial_out <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
          bit_index  <= '0;
        end
      endcase
    end
  end

endmodule
